// File: rtl/multi_channel_counter.sv
// Multi-channel prescaled counter: channel k advances once per 4^k enabled cycles,
// with a shared wrap/saturate overflow mode and per-channel one-cycle wrap flags.
module multi_channel_counter #(
    parameter int WIDTH = 64,
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   En,
    input  logic [SEL_W-1:0]       Slt,
    input  logic                   Clr,
    input  logic                   Mode,
    output logic [NCH*WIDTH-1:0]   Count_all,
    output logic [WIDTH-1:0]       Count_sel,
    output logic [NCH-1:0]         Wrap,
    output logic                   Sat
);

    localparam int PW = 2 * (NCH - 1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        // Terminal prescaler value; zero for channel 0 so its prescaler never moves.
        localparam logic [PW-1:0] LAST = PW'((64'd1 << (2 * k)) - 64'd1);
        localparam logic [SEL_W-1:0] KSEL = SEL_W'(k);

        logic [WIDTH-1:0] cnt_q;
        logic [PW-1:0]    pre_q;
        logic             wrap_q;
        logic             hit;

        assign hit = (Slt == KSEL);

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                cnt_q  <= '0;
                pre_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                wrap_q <= 1'b0;
                if (hit) begin
                    if (Clr) begin
                        cnt_q <= '0;
                        pre_q <= '0;
                    end else if (En) begin
                        if (pre_q == LAST) begin
                            pre_q <= '0;
                            if (cnt_q == {WIDTH{1'b1}}) begin
                                if (!Mode) begin
                                    cnt_q  <= '0;
                                    wrap_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                end
            end
        end

        assign Count_all[k*WIDTH +: WIDTH] = cnt_q;
        assign Wrap[k]                     = wrap_q;
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        Count_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (Slt == SEL_W'(k)) Count_sel = Count_all[k*WIDTH +: WIDTH];
        end
    end

    assign Sat = &Count_sel;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed and randomized bench for multi_channel_counter (WIDTH=8, NCH=4 plus an NCH=3 instance).
module tb_multi_channel_counter;

    localparam int W = 8;
    localparam int N = 4;

    logic           Clk;
    logic           Reset;
    logic           en, clr, mode;
    logic [1:0]     slt;
    logic [N*W-1:0] count_all;
    logic [W-1:0]   count_sel;
    logic [N-1:0]   wrap;
    logic           sat;

    logic           b_en, b_clr, b_mode;
    logic [1:0]     b_slt;
    logic [3*W-1:0] b_count_all;
    logic [W-1:0]   b_count_sel;
    logic [2:0]     b_wrap;
    logic           b_sat;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: enabled-event tally per channel, count derived by dividing by 4^k.
    int m_cnt [N];
    int m_ev  [N];
    int m_wrap[N];

    multi_channel_counter #(.WIDTH(W), .NCH(N), .SEL_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .En(en), .Slt(slt), .Clr(clr), .Mode(mode),
        .Count_all(count_all), .Count_sel(count_sel), .Wrap(wrap), .Sat(sat)
    );

    multi_channel_counter #(.WIDTH(W), .NCH(3), .SEL_W(2)) dut3 (
        .Clk(Clk), .Reset(Reset), .En(b_en), .Slt(b_slt), .Clr(b_clr), .Mode(b_mode),
        .Count_all(b_count_all), .Count_sel(b_count_sel), .Wrap(b_wrap), .Sat(b_sat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_ev[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_edge();
        int k;
        int period;
        for (int j = 0; j < N; j++) m_wrap[j] = 0;
        if (!Reset) begin
            model_reset();
        end else begin
            k = int'(slt);
            period = 1 << (2 * k);
            if (clr) begin
                m_cnt[k] = 0; m_ev[k] = 0;
            end else if (en) begin
                m_ev[k] = (m_ev[k] + 1) % period;
                if (m_ev[k] == 0) begin
                    if (m_cnt[k] == 255) begin
                        if (!mode) begin m_cnt[k] = 0; m_wrap[k] = 1; end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] exp_wrap;
        int exp_sel;
        for (int k = 0; k < N; k++) begin
            chk({tag, "_cnt"}, 64'(count_all[k*W +: W]), 64'(m_cnt[k]));
            exp_wrap[k] = m_wrap[k][0];
        end
        exp_sel = m_cnt[int'(slt)];
        chk({tag, "_wrap"}, 64'(wrap), 64'(exp_wrap));
        chk({tag, "_sel"},  64'(count_sel), 64'(exp_sel));
        chk({tag, "_sat"},  64'(sat), 64'(exp_sel == 255));
    endtask

    // Inputs are stable from the previous negedge; model tracks the edge, then check at negedge.
    task automatic cycle(input string tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        Reset = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b0; slt = 2'd0;
        b_en = 1'b0; b_clr = 1'b0; b_mode = 1'b0; b_slt = 2'd0;
        model_reset();
        @(negedge Clk);
        run(5, "reset");

        Reset = 1'b1; slt = 2'd0; en = 1'b1;
        run(10, "ch0_ten");
        chk("ch0_is_10", 64'(count_sel), 64'd10);
        chk("others_0", 64'(count_all[N*W-1:W]), 64'd0);

        slt = 2'd1;
        run(9, "ch1_nine");
        chk("ch1_is_2", 64'(count_sel), 64'd2);
        slt = 2'd0;
        run(3, "ch0_interleave");
        slt = 2'd1;
        run(3, "ch1_resume");
        chk("ch1_is_3", 64'(count_sel), 64'd3);

        slt = 2'd0; mode = 1'b0;
        run(242, "ch0_fill");
        chk("ch0_full", 64'(count_sel), 64'd255);
        chk("sat_full", 64'(sat), 64'd1);
        run(1, "ch0_wrap");
        chk("ch0_wrapped", 64'(count_sel), 64'd0);
        chk("wrap0_set", 64'(wrap), 64'd1);
        en = 1'b0;
        run(1, "wrap_clear");
        chk("wrap0_one_cycle", 64'(wrap), 64'd0);
        en = 1'b1;
        run(255, "ch0_refill");
        mode = 1'b1;
        run(3, "ch0_saturate");
        chk("ch0_held", 64'(count_sel), 64'd255);
        chk("sat_held", 64'(sat), 64'd1);
        chk("no_wrap_sat", 64'(wrap), 64'd0);
        mode = 1'b0;

        slt = 2'd2;
        run(80, "ch2_fill");
        chk("ch2_is_5", 64'(count_sel), 64'd5);
        clr = 1'b1;
        run(1, "ch2_clr");
        chk("ch2_cleared", 64'(count_sel), 64'd0);
        clr = 1'b0;
        run(15, "ch2_after_clr");
        chk("ch2_still_0", 64'(count_sel), 64'd0);
        run(1, "ch2_tick");
        chk("ch2_is_1", 64'(count_sel), 64'd1);

        slt = 2'd3;
        run(30, "ch3_partial");
        #2 Reset = 1'b0;
        #1 model_reset();
        chk("async_all", 64'(count_all), 64'd0);
        chk("async_wrap", 64'(wrap), 64'd0);
        @(negedge Clk);
        check_all("in_reset");
        Reset = 1'b1;
        run(63, "ch3_post_reset");
        chk("ch3_still_0", 64'(count_sel), 64'd0);
        run(1, "ch3_tick");
        chk("ch3_is_1", 64'(count_sel), 64'd1);

        for (int i = 0; i < 600; i++) begin
            slt  = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 9) < 8);
            clr  = ($urandom_range(0, 49) == 0);
            mode = ($urandom_range(0, 3) == 0);
            cycle("random");
        end
        en = 1'b0; clr = 1'b0; mode = 1'b0;

        b_slt = 2'd0; b_en = 1'b1;
        run(3, "b_fill");
        chk("b_ch0_3", 64'(b_count_all), 64'h000003);
        b_slt = 2'd3; b_clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("b_oor");
            chk("b_oor_all", 64'(b_count_all), 64'h000003);
            chk("b_oor_sel", 64'(b_count_sel), 64'd0);
            chk("b_oor_wrap", 64'(b_wrap), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_counter.md
MULTI_CHANNEL_COUNTER -- requirements
Module: multi_channel_counter

Interface
REQ-001 Parameter WIDTH, default 64: bit width of each channel count.
REQ-002 Parameter NCH, default 4, legal range 2..8: number of channels.
REQ-003 Parameter SEL_W, default 2, equal to ceil(log2(NCH)) with a minimum of 1: channel select width.
REQ-004 Clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 En  input  1: count enable for the selected channel.
REQ-007 Slt  input  SEL_W: channel select.
REQ-008 Clr  input  1: synchronous clear of the selected channel.
REQ-009 Mode  input  1: overflow mode for all channels; 0 = wrap, 1 = saturate.
REQ-010 Count_all  output  NCH*WIDTH: all channel counts; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Count_sel  output  WIDTH: count of channel Slt, combinational from Slt.
REQ-012 Wrap  output  NCH: registered per-channel wrap flags.
REQ-013 Sat  output  1: combinational; 1 when Count_sel equals all-ones.

Function
REQ-014 Each channel k SHALL own a count register (WIDTH bits) and a prescaler (2*(NCH-1) bits).
REQ-015 Channel k SHALL increment once per 4^k enabled cycles: ch0 every enabled cycle, ch1 every 4th, ch2 every 16th.
REQ-016 Enabled cycle for channel k: Clk edge with Reset=1, En=1, Clr=0 and Slt==k.
REQ-017 On an enabled cycle, if prescaler k == 4^k-1, prescaler k SHALL go to 0 and count k SHALL advance; otherwise prescaler k SHALL increment.
REQ-018 Channel 0's prescaler SHALL remain 0, so channel 0 advances every enabled cycle (1-cycle latency: new value visible after the edge).
REQ-019 Unselected channels SHALL hold count and prescaler unchanged; a partial prescale is retained across Slt changes.
REQ-020 Wrap mode: advancing from all-ones SHALL produce 0, with Wrap[k]=1 for exactly the cycle after that edge.
REQ-021 Saturate mode: a count at all-ones SHALL hold; the prescaler SHALL continue to cycle; Wrap[k] SHALL stay 0.
REQ-022 Wrap[k] SHALL be 0 on every edge where channel k does not wrap.
REQ-023 Clr=1 SHALL zero count, prescaler and Wrap bit of channel Slt on the next edge, regardless of En; Clr takes priority over En.
REQ-024 If Slt >= NCH, no channel SHALL update, Clr SHALL have no effect, and Count_sel SHALL read 0.
REQ-025 A Mode change SHALL take effect on the next edge, with no effect on stored values.

Reset
REQ-026 Reset=0 SHALL immediately, independent of Clk, force all counts, prescalers and Wrap to 0; Count_all=0, Wrap=0.
REQ-027 While Reset=0, En and Clr SHALL be ignored; counting SHALL resume on the first rising edge after Reset returns to 1.
REQ-028 Reset asserted mid-prescale SHALL discard partial prescale progress.

Verification (WIDTH=8, NCH=4 unless noted)
REQ-029 Reset low 5 cycles, then Slt=0, En=1 for 10 cycles -> Count_sel=10, all other channels 0, Wrap=0.
REQ-030 Slt=1, En=1 for 9 cycles -> ch1=2; Slt=0 for 3 cycles, then Slt=1 for 3 more cycles -> ch1=3 (prescaler retained).
REQ-031 Mode=0, ch0 driven to 255, one more enabled cycle -> ch0=0, Wrap[0]=1 for one cycle only; Mode=1 repeat at 255 -> stays 255, Sat=1, Wrap[0]=0.
REQ-032 Slt=2, En=1, Clr=1 on the same edge with ch2=5 -> ch2=0, prescaler 0; next 16 enabled cycles -> ch2=1.
REQ-033 Reset pulsed low between clock edges while ch3 prescaler is mid-count -> outputs zero immediately; after release, 64 enabled cycles -> ch3=1.
REQ-034 NCH=3, Slt=3, En=1, Clr=1 for 5 cycles -> no count change, Count_sel=0.
